// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Purpose  : WIDTH-bit adder/subtractor whose carry chain is cut into
//            CHUNK-bit slices, one slice resolved per pipeline stage.
//            Valid/ready handshake on both sides, one beat per cycle.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            in_valid_i        - operand beat valid
//            in_ready_o        - beat accepted this cycle (= advance enable)
//            a_i, b_i          - operands
//            cin_i             - carry-in, ignored when sub_i=1
//            sub_i             - 0: a+b+cin, 1: a-b
//            out_valid_o       - result beat valid
//            out_ready_i       - downstream accepts result
//            sum_o             - result modulo 2^WIDTH
//            cout_o            - carry out of MSB (sub: 1 = no borrow)
//            ovf_o             - signed two's-complement overflow
// Revision : 1.0 - initial release
// ============================================================================
// WIDTH must be a multiple of CHUNK and at least CHUNK.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;

  // Per-stage pipeline registers. Each stage carries the full operand words
  // (upper slices still to be added) and the partially built result word
  // (lower slices already resolved), so one beat stays together end to end.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic              ovf_q;

  // Stage inputs: index 0 is the input port side, index k the output of k-1.
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_r [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [CHUNK:0]    slice_d [STAGES];
  logic [STAGES-1:0] cy_d;
  logic              ovf_d;
  logic              adv;

  // The whole pipeline moves together; it only stops when a finished result
  // is waiting at the output and downstream refuses it.
  assign adv        = ~vld_q[LAST] | out_ready_i;
  assign in_ready_o = adv;

  always_comb begin
    src_v[0] = in_valid_i;
    src_a[0] = a_i;
    src_b[0] = sub_i ? ~b_i : b_i;
    src_c[0] = sub_i | cin_i;
    src_r[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = vld_q[k-1];
      src_a[k] = opa_q[k-1];
      src_b[k] = opb_q[k-1];
      src_c[k] = cy_q[k-1];
      src_r[k] = res_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_d[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_c[k]};
      res_d[k]   = src_r[k];
      res_d[k][k*CHUNK +: CHUNK] = slice_d[k][CHUNK-1:0];
      cy_d[k]    = slice_d[k][CHUNK];
    end
    // Overflow is resolved alongside the top slice and registered with it,
    // so every output comes straight from a flop.
    ovf_d = (src_a[LAST][MSB] == src_b[LAST][MSB]) &
            (res_d[LAST][MSB] != src_a[LAST][MSB]);
  end

  // Bubbles load whatever their source holds; only vld_q is meaningful for
  // an invalid slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        res_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= src_v[k];
        cy_q[k]  <= cy_d[k];
        opa_q[k] <= src_a[k];
        opb_q[k] <= src_b[k];
        res_q[k] <= res_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid_o = vld_q[LAST];
  assign sum_o       = res_q[LAST];
  assign cout_o      = cy_q[LAST];
  assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_addsub
// Purpose  : Scoreboard bench for pipelined_addsub. Two instances: an 8-bit
//            (CHUNK=4, two stages) and a 32-bit (CHUNK=8, four stages).
//            Drivers push expected {cout, ovf, sum} into per-instance queues;
//            monitors pop and compare whenever a result retires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
  logic [7:0]  a8, b8, s8;
  logic        iv32, ir32, cin32, sub32, ov32, or32, co32, of32;
  logic [31:0] a32, b32, s32;

  int checks = 0;
  int errors = 0;

  logic [9:0]  q8  [$];
  logic [33:0] q32 [$];

  logic        bp_en = 1'b0;
  logic [15:0] bp_pat = 16'b1011_0010_0111_0100;

  pipelined_addsub #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid_i(iv8), .in_ready_o(ir8),
    .a_i(a8), .b_i(b8), .cin_i(cin8), .sub_i(sub8),
    .out_valid_o(ov8), .out_ready_i(or8),
    .sum_o(s8), .cout_o(co8), .ovf_o(of8)
  );

  pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid_i(iv32), .in_ready_o(ir32),
    .a_i(a32), .b_i(b32), .cin_i(cin32), .sub_i(sub32),
    .out_valid_o(ov32), .out_ready_i(or32),
    .sum_o(s32), .cout_o(co32), .ovf_o(of32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  logic [9:0] hold8;
  logic       stall8 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall8 = 1'b0;
    end else begin
      if (stall8) chk("stable8", {ov8, co8, of8, s8}, {1'b1, hold8});
      if (ov8 && or8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected8: got 0x%0h, expected no result", {co8, of8, s8});
        end else begin
          chk("result8", {co8, of8, s8}, q8.pop_front());
        end
        stall8 = 1'b0;
      end else if (ov8) begin
        hold8  = {co8, of8, s8};
        stall8 = 1'b1;
      end else begin
        stall8 = 1'b0;
      end
    end
  end

  logic [33:0] hold32;
  logic        stall32 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall32 = 1'b0;
    end else begin
      if (stall32) chk("stable32", {ov32, co32, of32, s32}, {1'b1, hold32});
      if (ov32 && or32) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected32: got 0x%0h, expected no result", {co32, of32, s32});
        end else begin
          chk("result32", {co32, of32, s32}, q32.pop_front());
        end
        stall32 = 1'b0;
      end else if (ov32) begin
        hold32  = {co32, of32, s32};
        stall32 = 1'b1;
      end else begin
        stall32 = 1'b0;
      end
    end
  end

  // Pseudo-random backpressure for the 32-bit instance.
  always begin
    @(posedge clk);
    #2;
    if (bp_en) begin
      or32   = bp_pat[15];
      bp_pat = {bp_pat[14:0], bp_pat[15] ^ bp_pat[13] ^ bp_pat[12] ^ bp_pat[10]};
    end else begin
      or32 = 1'b1;
    end
  end

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic s, input logic [9:0] e);
    logic acc;
    int   n;
    q8.push_back(e);
    a8 = a; b8 = b; cin8 = c; sub8 = s; iv8 = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = ir8;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept8: got no acceptance, expected acceptance within 100 cycles");
    end
    iv8 = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s, input logic [33:0] e);
    logic acc;
    int   n;
    q32.push_back(e);
    a32 = a; b32 = b; cin32 = c; sub32 = s; iv32 = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = ir32;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept32: got no acceptance, expected acceptance within 100 cycles");
    end
    iv32 = 1'b0;
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain8", q8.size(), 0);
  endtask

  task automatic drain32();
    int n = 0;
    while (q32.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain32", q32.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ta, tb, tbe;
    logic [32:0] tsum;
    logic        tc, ts;
    int          first, run, maxrun;

    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid8", ov8, 0);
    chk("rst_out8", {co8, of8, s8}, 0);
    chk("rst_ready8", ir8, 1);
    chk("rst_valid32", ov32, 0);
    chk("rst_out32", {co32, of32, s32}, 0);
    chk("rst_ready32", ir32, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: two-stage instance, valid after the second edge.
    q8.push_back({1'b0, 1'b0, 8'h4C});
    a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b1; sub8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    chk("lat8_edge1_valid", ov8, 0);
    @(posedge clk);
    #1;
    chk("lat8_edge2_valid", ov8, 1);
    chk("lat8_edge2_sum", s8, 8'h4C);

    // Directed 8-bit vectors, back to back.
    send8(8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h00});
    send8(8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h80});
    send8(8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFE});
    send8(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
    send8(8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h10});
    send8(8'h00, 8'h00, 1'b0, 1'b1, {1'b1, 1'b0, 8'h00});
    drain8();

    // Stall: hold output, then retire and accept on the same edge.
    or8 = 1'b0;
    send8(8'h10, 8'h20, 1'b0, 1'b0, {1'b0, 1'b0, 8'h30});
    send8(8'hC0, 8'h40, 1'b0, 1'b0, {1'b1, 1'b0, 8'h00});
    q8.push_back({1'b1, 1'b0, 8'h20});
    a8 = 8'h50; b8 = 8'h30; cin8 = 1'b0; sub8 = 1'b1; iv8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stall8_ready", ir8, 0);
    chk("stall8_valid", ov8, 1);
    chk("stall8_sum", s8, 8'h30);
    or8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    drain8();

    // 32-bit directed vectors under backpressure.
    bp_en = 1'b1;
    send32(32'h00000001, 32'h00000001, 1'b0, 1'b0, {2'b00, 32'h00000002});
    send32(32'h000000FF, 32'h00000001, 1'b0, 1'b0, {2'b00, 32'h00000100});
    send32(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, {2'b00, 32'h01000000});
    send32(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, {2'b10, 32'h00000000});
    send32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {2'b01, 32'h80000000});
    send32(32'h80000000, 32'h80000000, 1'b0, 1'b0, {2'b11, 32'h00000000});
    send32(32'h12345678, 32'h12345678, 1'b0, 1'b1, {2'b10, 32'h00000000});
    send32(32'h00000000, 32'h00000001, 1'b0, 1'b1, {2'b00, 32'hFFFFFFFF});
    send32(32'h80000000, 32'h00000001, 1'b1, 1'b1, {2'b11, 32'h7FFFFFFF});
    send32(32'h12345678, 32'h11111111, 1'b1, 1'b0, {2'b00, 32'h2345678A});
    drain32();
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Throughput: 16 consecutive beats, out_ready held high.
    first = -1; run = 0; maxrun = 0;
    for (int k = 0; k < 24; k++) begin
      if (k < 16) begin
        ta  = 32'h9E3779B9 * k;
        tb  = 32'h7F4A7C15 ^ (k << 20);
        ts  = k[1];
        tc  = k[0];
        tbe = ts ? ~tb : tb;
        tsum = {1'b0, ta} + {1'b0, tbe} + {32'b0, (ts | tc)};
        q32.push_back({tsum[32], (ta[31] == tbe[31]) && (tsum[31] != ta[31]), tsum[31:0]});
        a32 = ta; b32 = tb; cin32 = tc; sub32 = ts; iv32 = 1'b1;
      end else begin
        iv32 = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k < 16) chk("tput_ready", ir32, 1);
      if (ov32) begin
        if (first < 0) first = k;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    chk("tput_first_valid_edge", first, 3);
    chk("tput_consecutive", maxrun, 16);
    drain32();

    // Reset with three beats in flight: none may ever emerge.
    for (int k = 0; k < 3; k++) begin
      a32 = 32'hA5A5A5A5 + k; b32 = 32'h5A5A5A5A; cin32 = 1'b1; sub32 = 1'b0; iv32 = 1'b1;
      @(posedge clk);
      #1;
    end
    iv32 = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", ov32, 0);
    chk("midrst_out", {co32, of32, s32}, 0);
    chk("midrst_ready", ir32, 1);
    q32.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_ready", ir32, 1);
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ov32) chk("postrst_no_old_beat", ov32, 0);
    end
    chk("postrst_valid", ov32, 0);

    chk("final_q8_empty", q8.size(), 0);
    chk("final_q32_empty", q32.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
